cc_branch_unit: RTL and testbench
=================================

# cc_branch_unit

Parametrised condition-code and branch-evaluation unit for the TB4004 core. It owns the carry flag, the synchronised TEST flag and the accumulator-zero flag. It tracks two-word instructions so that second-word address bytes are never decoded as opcodes, and evaluates JCN/ISZ branch decisions. It sits beside the instruction decoder, samples opr/opa and the A1..X3 cycle counter, and drives jumpTaken to the program-counter logic.

## Interface
- DATA_W, 4: accumulator width; zero test covers all DATA_W bits.
- SYNC_STAGES, 2: TEST synchroniser depth; legal values ≥2.
- X3_CYCLE, 7: cycle-counter value at which the instruction commits.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- opr  in  4  upper nibble of fetched ROM word.
- opa  in  4  lower nibble of fetched ROM word.
- cycle  in  3  machine cycle, 0=A1 … 7=X3.
- accIn  in  DATA_W  accumulator value, valid at X3_CYCLE.
- aluCarry  in  1  ALU carry/borrow result, valid at X3_CYCLE.
- regZero  in  1  ISZ incremented register equals zero, valid at X3_CYCLE.
- testIn  in  1  external TEST pin, asynchronous, active-low.
- carryFlag  out  1  CY register.
- zeroFlag  out  1  accumulator-zero flag.
- testFlag  out  1  synchronised TEST level.
- secondWord  out  1  high while the current fetch is the second word of a two-word instruction.
- jumpTaken  out  1  one-clk pulse: branch taken.

## Operation
- State register, two states: FIRST and SECOND. Reset → FIRST.
- FIRST, cycle==X3_CYCLE, opr ∈ {1 JCN, 4 JUN, 5 JMS, 7 ISZ}, or opr==2 with opa[0]==0 (FIM): next state SECOND.
- SECOND, cycle==X3_CYCLE: next state FIRST. In SECOND, opr/opa are data. No flag update and no opcode decode.
- Branch latch, captured at X3 of the first word:
  - JCN, opa=C1C2C3C4 (bit3..0): cond = (C2 & accIn==0) | (C3 & carryFlag) | (C4 & ~testFlag); taken = cond ^ C1.
  - ISZ: taken = ~regZero.
  - JUN/JMS/FIM: taken = 0.
  - jumpTaken pulses only for JCN/ISZ.
- Carry updates occur only in FIRST at X3_CYCLE:
  - opr F: CLB(0), CLC(1), TCC(7), TCS(9) → 0. STC(A) → 1. CMC(3) → ~carryFlag. IAC(2), RAL(5), RAR(6), DAC(8), DAA(B) → aluCarry.
  - opr 8 ADD, opr 9 SUB → aluCarry.
  - opr E with opa ∈ {8 SBM, B ADM} → aluCarry.
  - All other opcodes hold the flag.
- zeroFlag ← (accIn==0) at every FIRST-state X3_CYCLE.
- Reset values: carryFlag 0, zeroFlag 0, testFlag 1, secondWord 0, jumpTaken 0, branch latch 0.
- Reset mid-instruction, including during SECOND: immediate return to FIRST. The next X3 is decoded as a first word.

## Timing
- All outputs are registered. A flag sampled at the X3_CYCLE edge is visible from the following clk.
- jumpTaken goes high on the edge where SECOND && cycle==X3_CYCLE, for exactly one clk.
- secondWord rises the clk after the first-word X3 and falls the clk after the second-word X3.
- A JCN condition uses flag values as they stand before the X3 edge of its own first word.
- cycle values other than X3_CYCLE have no effect apart from the TEST pipeline.

## Configuration
- CC_TEST_SYNC_EN defined: testIn passes through SYNC_STAGES flops, all reset to 1. testFlag is the last stage, giving SYNC_STAGES clk latency.
- CC_TEST_SYNC_EN undefined: a single reset-to-1 flop, 1 clk latency.

## Structure
- tb4004_pkg holds:
  - opr codes (NOP … F_);
  - F-group and E-group opa codes;
  - cycle encodings A1 … X3;
  - the FIRST/SECOND state enum.
- Sub-module cc_test_sync, parametrised by SYNC_STAGES, is instantiated under the macro.

## Test plan
- Reset asserted asynchronously mid-cycle → carryFlag 0, zeroFlag 0, testFlag 1, secondWord 0, jumpTaken 0, without a clk edge.
- STC (0xFA), then JCN 0x12 followed by address 0x40 → carryFlag 1; jumpTaken pulses once at the second-word X3.
- carryFlag 1, JCN 0x1A (inverted carry) → jumpTaken stays 0 and carryFlag remains 1.
- CMC twice, then ADD with aluCarry=1 → carryFlag goes 1, 0, then 1.
- testIn driven 0 → testFlag 0 after 2 clk with the macro, 1 clk without. JCN 0x11 is then taken.
- FIM 0x20 with second word 0xF1, rst pulsed in SECOND → carry is not cleared by 0xF1 and secondWord returns 0. A following 0xF1 in FIRST clears carry.

Source files
------------

// File: rtl/tb4004_pkg.sv
// -----------------------------------------------------------------------------
// tb4004_pkg
// Shared definitions for the TB4004 core condition-code / branch logic:
//   - opr_e          : upper-nibble opcode groups (NOP .. F_)
//   - FOPA_* / EOPA_*: opa sub-codes of the F (accumulator) and E (I/O) groups
//   - cycle_e        : machine-cycle counter encodings A1 .. X3
//   - word_state_e   : FIRST/SECOND word tracking state
//   - is_two_word()  : true when a first word starts a two-word instruction
// -----------------------------------------------------------------------------
package tb4004_pkg;

   typedef enum logic [3:0] {
      OPR_NOP = 4'h0,
      OPR_JCN = 4'h1,
      OPR_FIM = 4'h2,
      OPR_FIN = 4'h3,
      OPR_JUN = 4'h4,
      OPR_JMS = 4'h5,
      OPR_INC = 4'h6,
      OPR_ISZ = 4'h7,
      OPR_ADD = 4'h8,
      OPR_SUB = 4'h9,
      OPR_LD  = 4'hA,
      OPR_XCH = 4'hB,
      OPR_BBL = 4'hC,
      OPR_LDM = 4'hD,
      OPR_E_  = 4'hE,
      OPR_F_  = 4'hF
   } opr_e;

   // F-group (accumulator group) opa codes
   localparam logic [3:0] FOPA_CLB = 4'h0;
   localparam logic [3:0] FOPA_CLC = 4'h1;
   localparam logic [3:0] FOPA_IAC = 4'h2;
   localparam logic [3:0] FOPA_CMC = 4'h3;
   localparam logic [3:0] FOPA_CMA = 4'h4;
   localparam logic [3:0] FOPA_RAL = 4'h5;
   localparam logic [3:0] FOPA_RAR = 4'h6;
   localparam logic [3:0] FOPA_TCC = 4'h7;
   localparam logic [3:0] FOPA_DAC = 4'h8;
   localparam logic [3:0] FOPA_TCS = 4'h9;
   localparam logic [3:0] FOPA_STC = 4'hA;
   localparam logic [3:0] FOPA_DAA = 4'hB;
   localparam logic [3:0] FOPA_KBP = 4'hC;
   localparam logic [3:0] FOPA_DCL = 4'hD;

   // E-group opa codes that touch the carry
   localparam logic [3:0] EOPA_SBM = 4'h8;
   localparam logic [3:0] EOPA_ADM = 4'hB;

   typedef enum logic [2:0] {
      CYC_A1 = 3'd0,
      CYC_A2 = 3'd1,
      CYC_A3 = 3'd2,
      CYC_M1 = 3'd3,
      CYC_M2 = 3'd4,
      CYC_X1 = 3'd5,
      CYC_X2 = 3'd6,
      CYC_X3 = 3'd7
   } cycle_e;

   typedef enum logic {
      ST_FIRST  = 1'b0,
      ST_SECOND = 1'b1
   } word_state_e;

   // JCN, JUN, JMS, ISZ and FIM (opr 2 with even opa; odd opa is SRC) carry a second word
   function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
      logic two_s;
      case (opr)
         OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: two_s = 1'b1;
         OPR_FIM:                            two_s = ~opa[0];
         default:                            two_s = 1'b0;
      endcase
      return two_s;
   endfunction

endpackage

// File: rtl/cc_test_sync.sv
// -----------------------------------------------------------------------------
// cc_test_sync
// Multi-stage synchroniser for the asynchronous, active-low TEST pin. All
// stages reset to 1 (pin inactive); testFlag is the last stage, so a pin
// change is visible SYNC_STAGES clocks later.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-high reset
//   testIn   in  raw TEST pin
//   testFlag out synchronised TEST level
// Parameters:
//   SYNC_STAGES  synchroniser depth, must be >= 2
// -----------------------------------------------------------------------------
module cc_test_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic testIn,
   output logic testFlag
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   // Shift the raw pin into stage 0 and move older samples toward the output
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], testIn};
   end

   // Synchroniser flops, reset to the inactive pin level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{1'b1}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign testFlag = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cc_branch_unit.sv
// -----------------------------------------------------------------------------
// cc_branch_unit
// Condition-code and branch-evaluation unit for the TB4004 core. Owns the
// carry flag, the synchronised TEST flag and the accumulator-zero flag, tracks
// two-word instructions so that second-word address bytes are never decoded,
// and evaluates JCN/ISZ branch decisions. Everything commits on the clock edge
// where cycle == X3_CYCLE.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   opr, opa    upper/lower nibble of the fetched ROM word
//   cycle       machine cycle, 0=A1 .. 7=X3
//   accIn       accumulator value (valid at X3)
//   aluCarry    ALU carry/borrow (valid at X3)
//   regZero     ISZ incremented register is zero (valid at X3)
//   testIn      external TEST pin, asynchronous, active-low
//   carryFlag   CY register
//   zeroFlag    accumulator-zero flag
//   testFlag    synchronised TEST level
//   secondWord  current fetch is the second word of a two-word instruction
//   jumpTaken   one-clock pulse at the second-word X3 when the branch is taken
// Configuration:
//   CC_TEST_SYNC_EN defined   : TEST goes through SYNC_STAGES flops (cc_test_sync)
//   CC_TEST_SYNC_EN undefined : TEST goes through a single flop
// -----------------------------------------------------------------------------
module cc_branch_unit
   import tb4004_pkg::*;
#(
   parameter int DATA_W      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int X3_CYCLE    = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        opr,
   input  logic [3:0]        opa,
   input  logic [2:0]        cycle,
   input  logic [DATA_W-1:0] accIn,
   input  logic              aluCarry,
   input  logic              regZero,
   input  logic              testIn,
   output logic              carryFlag,
   output logic              zeroFlag,
   output logic              testFlag,
   output logic              secondWord,
   output logic              jumpTaken
);

   word_state_e state_q, state_d;
   logic        carry_q, carry_d;
   logic        zero_q,  zero_d;
   logic        branch_q, branch_d;
   logic        jump_q,  jump_d;

   logic        is_x3_s;
   logic        acc_zero_s;
   logic        jcn_taken_s;

`ifdef CC_TEST_SYNC_EN
   cc_test_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_test_sync (
      .clk      (clk),
      .rst      (rst),
      .testIn   (testIn),
      .testFlag (testFlag)
   );
`else
   logic test_q;
   logic test_d;
   // Depth is fixed at one flop in this build; keep the parameter referenced
   logic unused_sync_stages_s;
   assign unused_sync_stages_s = (SYNC_STAGES > 0);

   // Single-flop TEST sampling
   always_comb begin
      test_d = testIn;
   end

   // TEST flop, reset to the inactive pin level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         test_q <= 1'b1;
      end else begin
         test_q <= test_d;
      end
   end

   assign testFlag = test_q;
`endif

   assign is_x3_s    = (cycle == 3'(X3_CYCLE));
   assign acc_zero_s = (accIn == {DATA_W{1'b0}});

   // JCN opa = C1 C2 C3 C4; the condition sees flags as they stand before this X3 edge
   assign jcn_taken_s = ((opa[2] & acc_zero_s) | (opa[1] & carry_q) | (opa[0] & ~testFlag)) ^ opa[3];

   // Next-state, flag and branch-latch logic; only the X3 cycle changes anything
   always_comb begin
      state_d  = state_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      branch_d = branch_q;
      jump_d   = 1'b0;
      if (is_x3_s) begin
         if (state_q == ST_FIRST) begin
            zero_d  = acc_zero_s;
            state_d = is_two_word(opr, opa) ? ST_SECOND : ST_FIRST;

            case (opr)
               OPR_JCN: branch_d = jcn_taken_s;
               OPR_ISZ: branch_d = ~regZero;
               default: branch_d = 1'b0;
            endcase

            case (opr)
               OPR_F_: begin
                  case (opa)
                     FOPA_CLB, FOPA_CLC, FOPA_TCC, FOPA_TCS:           carry_d = 1'b0;
                     FOPA_STC:                                         carry_d = 1'b1;
                     FOPA_CMC:                                         carry_d = ~carry_q;
                     FOPA_IAC, FOPA_RAL, FOPA_RAR, FOPA_DAC, FOPA_DAA: carry_d = aluCarry;
                     default:                                          carry_d = carry_q;
                  endcase
               end
               OPR_ADD, OPR_SUB: carry_d = aluCarry;
               OPR_E_: begin
                  if ((opa == EOPA_SBM) || (opa == EOPA_ADM)) begin
                     carry_d = aluCarry;
                  end else begin
                     carry_d = carry_q;
                  end
               end
               default: carry_d = carry_q;
            endcase
         end else begin
            // Second word is pure data: no decode, no flag update
            state_d = ST_FIRST;
            jump_d  = branch_q;
         end
      end else begin
         jump_d = 1'b0;
      end
   end

   // State, flags, branch latch and jump pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_FIRST;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         branch_q <= 1'b0;
         jump_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         branch_q <= branch_d;
         jump_q   <= jump_d;
      end
   end

   assign carryFlag  = carry_q;
   assign zeroFlag   = zero_q;
   assign secondWord = (state_q == ST_SECOND);
   assign jumpTaken  = jump_q;

endmodule

// File: tb/tb_cc_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_cc_branch_unit
// Directed bench for cc_branch_unit. Each instruction word is driven through
// cycles A1..X3; a reference model pushes the expected flag state to a
// scoreboard queue when the word is driven, and it is popped and compared
// after the word's X3 edge.
// -----------------------------------------------------------------------------
module tb_cc_branch_unit;

`ifdef CC_TEST_SYNC_EN
   localparam int TEST_LAT = 2;
`else
   localparam int TEST_LAT = 1;
`endif

   logic       clk;
   logic       rst;
   logic [3:0] opr;
   logic [3:0] opa;
   logic [2:0] cycle;
   logic [3:0] accIn;
   logic       aluCarry;
   logic       regZero;
   logic       testIn;
   logic       carryFlag;
   logic       zeroFlag;
   logic       testFlag;
   logic       secondWord;
   logic       jumpTaken;

   cc_branch_unit #(
      .DATA_W      (4),
      .SYNC_STAGES (2),
      .X3_CYCLE    (7)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .opr        (opr),
      .opa        (opa),
      .cycle      (cycle),
      .accIn      (accIn),
      .aluCarry   (aluCarry),
      .regZero    (regZero),
      .testIn     (testIn),
      .carryFlag  (carryFlag),
      .zeroFlag   (zeroFlag),
      .testFlag   (testFlag),
      .secondWord (secondWord),
      .jumpTaken  (jumpTaken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic carry;
      logic zero;
      logic test;
      logic second;
      logic jump;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   // reference model state
   logic m_carry, m_zero, m_test, m_second, m_branch;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input exp_t e);
      check({tag, ".carry"},  {7'd0, carryFlag},  {7'd0, e.carry});
      check({tag, ".zero"},   {7'd0, zeroFlag},   {7'd0, e.zero});
      check({tag, ".test"},   {7'd0, testFlag},   {7'd0, e.test});
      check({tag, ".second"}, {7'd0, secondWord}, {7'd0, e.second});
      check({tag, ".jump"},   {7'd0, jumpTaken},  {7'd0, e.jump});
   endtask

   task automatic model_reset();
      m_carry  = 1'b0;
      m_zero   = 1'b0;
      m_test   = 1'b1;
      m_second = 1'b0;
      m_branch = 1'b0;
      sb_q.delete();
   endtask

   // Expected result of one word at its X3 edge, pushed to the scoreboard
   task automatic model_word(input logic [3:0] o, input logic [3:0] a, input logic [3:0] acc,
                             input logic alu, input logic rz);
      exp_t e;
      logic jmp;
      logic cond;
      jmp = 1'b0;
      if (!m_second) begin
         if (o == 4'h1) begin
            cond     = (a[2] && acc == 4'h0) || (a[1] && m_carry) || (a[0] && !m_test);
            m_branch = cond ^ a[3];
         end else if (o == 4'h7) begin
            m_branch = !rz;
         end else begin
            m_branch = 1'b0;
         end
         if (o == 4'hF) begin
            if (a == 4'h0 || a == 4'h1 || a == 4'h7 || a == 4'h9) m_carry = 1'b0;
            else if (a == 4'hA) m_carry = 1'b1;
            else if (a == 4'h3) m_carry = !m_carry;
            else if (a == 4'h2 || a == 4'h5 || a == 4'h6 || a == 4'h8 || a == 4'hB) m_carry = alu;
         end else if (o == 4'h8 || o == 4'h9) begin
            m_carry = alu;
         end else if (o == 4'hE && (a == 4'h8 || a == 4'hB)) begin
            m_carry = alu;
         end
         m_zero   = (acc == 4'h0);
         m_second = (o == 4'h1 || o == 4'h4 || o == 4'h5 || o == 4'h7 || (o == 4'h2 && !a[0]));
      end else begin
         jmp      = m_branch;
         m_second = 1'b0;
      end
      e.carry  = m_carry;
      e.zero   = m_zero;
      e.test   = m_test;
      e.second = m_second;
      e.jump   = jmp;
      sb_q.push_back(e);
   endtask

   // Drive one ROM word through A1..X3 and score the result after the X3 edge
   task automatic exec_word(input string tag, input logic [3:0] o, input logic [3:0] a,
                            input logic [3:0] acc, input logic alu, input logic rz);
      exp_t e;
      model_word(o, a, acc, alu, rz);
      for (int c = 0; c < 8; c++) begin
         opr      = o;
         opa      = a;
         cycle    = 3'(c);
         accIn    = (c == 7) ? acc : ~acc;
         aluCarry = (c == 7) ? alu : ~alu;
         regZero  = (c == 7) ? rz  : ~rz;
         @(posedge clk);
         #1;
         if (c == 0) check({tag, ".jump_idle"}, {7'd0, jumpTaken}, 8'd0);
      end
      if (sb_q.size() == 0) begin
         check({tag, ".sb_empty"}, 8'd1, 8'd0);
      end else begin
         e = sb_q.pop_front();
         check_all(tag, e);
      end
   endtask

   // Non-X3 cycles with a carry-clearing opcode on the bus: must change nothing
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         opr   = 4'hF;
         opa   = 4'h1;
         cycle = 3'd0;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t r;
      r = '0;
      r.test = 1'b1;
      rst = 1'b1; opr = 4'h0; opa = 4'h0; cycle = 3'd0;
      accIn = 4'h0; aluCarry = 1'b0; regZero = 1'b0; testIn = 1'b1;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      check_all("por", r);
      rst = 1'b0;

      // STC then JCN on carry with address 0x40: taken
      exec_word("stc", 4'hF, 4'hA, 4'h5, 1'b0, 1'b0);
      exec_word("jcn12_w1", 4'h1, 4'h2, 4'h5, 1'b0, 1'b0);
      exec_word("jcn12_w2", 4'h4, 4'h0, 4'h5, 1'b0, 1'b0);
      // inverted carry condition: not taken, carry untouched
      exec_word("jcn1a_w1", 4'h1, 4'hA, 4'h5, 1'b0, 1'b0);
      exec_word("jcn1a_w2", 4'h4, 4'h0, 4'h5, 1'b0, 1'b0);
      idle(3);
      // CLC, CMC, CMC, ADD with carry in
      exec_word("clc", 4'hF, 4'h1, 4'h3, 1'b1, 1'b0);
      exec_word("cmc1", 4'hF, 4'h3, 4'h3, 1'b0, 1'b0);
      exec_word("cmc2", 4'hF, 4'h3, 4'h3, 1'b1, 1'b0);
      exec_word("add", 4'h8, 4'h2, 4'h3, 1'b1, 1'b0);
      exec_word("tcs", 4'hF, 4'h9, 4'h0, 1'b1, 1'b0);
      exec_word("daa", 4'hF, 4'hB, 4'h1, 1'b1, 1'b0);
      exec_word("wrm_hold", 4'hE, 4'h0, 4'h1, 1'b0, 1'b0);
      exec_word("sbm", 4'hE, 4'h8, 4'h1, 1'b0, 1'b0);
      exec_word("ldm_hold", 4'hD, 4'h7, 4'h7, 1'b1, 1'b0);

      // TEST pin latency, then JCN on TEST
      testIn = 1'b0;
      for (int k = 1; k <= TEST_LAT; k++) begin
         idle(1);
         check($sformatf("test_lat%0d", k), {7'd0, testFlag}, (k < TEST_LAT) ? 8'd1 : 8'd0);
      end
      m_test = 1'b0;
      exec_word("jcn11_w1", 4'h1, 4'h1, 4'h5, 1'b0, 1'b0);
      exec_word("jcn11_w2", 4'h7, 4'h3, 4'h5, 1'b0, 1'b0);
      testIn = 1'b1;
      idle(TEST_LAT + 1);
      m_test = 1'b1;

      // accumulator-zero branch, ISZ taken / not taken
      exec_word("jcn14_w1", 4'h1, 4'h4, 4'h0, 1'b1, 1'b0);
      exec_word("jcn14_w2", 4'h1, 4'h4, 4'h0, 1'b1, 1'b0);
      exec_word("isz_t_w1", 4'h7, 4'h5, 4'h2, 1'b0, 1'b0);
      exec_word("isz_t_w2", 4'h0, 4'h0, 4'h2, 1'b0, 1'b0);
      exec_word("isz_n_w1", 4'h7, 4'h5, 4'h2, 1'b0, 1'b1);
      exec_word("isz_n_w2", 4'h0, 4'h0, 4'h2, 1'b0, 1'b1);

      // FIM second word 0xF1 is data, carry kept
      exec_word("stc2", 4'hF, 4'hA, 4'h9, 1'b0, 1'b0);
      exec_word("fim_w1", 4'h2, 4'h0, 4'h9, 1'b0, 1'b0);
      exec_word("fim_w2", 4'hF, 4'h1, 4'h9, 1'b0, 1'b0);

      // FIM again, asynchronous reset in the middle of the second word
      exec_word("fim2_w1", 4'h2, 4'h0, 4'h9, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         opr = 4'hF; opa = 4'h1; cycle = 3'(c);
         @(posedge clk);
         #1;
      end
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("rst_mid", r);
      @(posedge clk);
      #1 rst = 1'b0;
      exec_word("post_rst_stc", 4'hF, 4'hA, 4'h4, 1'b0, 1'b0);
      exec_word("first_clc", 4'hF, 4'h1, 4'h4, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
